// File: rtl/sdram_pkg.sv
// sdram_pkg: shared SDRAM command encodings, address field positions, idle pin values and timing helpers.
package sdram_pkg;
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_BST = 4'b0110;
  localparam int BANK_MSB = 23;
  localparam int BANK_LSB = 22;
  localparam int ROW_MSB  = 21;
  localparam int ROW_LSB  = 9;
  localparam int COL_MSB  = 8;
  localparam int COL_LSB  = 0;
  localparam logic [1:0]  IDLE_BANK    = 2'b11;
  localparam logic [12:0] IDLE_ADDR    = 13'h1fff;
  localparam logic [12:0] PRE_ALL_ADDR = 13'h0400;
  typedef enum logic [3:0] {
    ST_IDLE, ST_ACT, ST_TRCD, ST_RD, ST_DATA, ST_PRE, ST_TRP, ST_END
  } rd_state_t;
  // Terminal count of an n-cycle wait state; a zero request still spends one cycle.
  function automatic logic [9:0] cyc_last(input int unsigned cyc);
    return (cyc == 0) ? 10'd0 : 10'(cyc - 1);
  endfunction
endpackage

// File: rtl/sdram_rd_vld_pipe.sv
// sdram_rd_vld_pipe: delays the read-issue strobe by CAS latency and captures DQ aligned to it.
module sdram_rd_vld_pipe #(
  parameter int unsigned CAS_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iss_i,
  input  logic [15:0] dq_i,
  output logic        ack_o,
  output logic [15:0] data_o,
  output logic        busy_o
);
  logic [CAS_LAT-1:0] sr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr_q   <= '0;
      ack_o  <= 1'b0;
      data_o <= '0;
    end else begin
      sr_q   <= {sr_q[CAS_LAT-2:0], iss_i};
      ack_o  <= sr_q[CAS_LAT-1];
      data_o <= sr_q[CAS_LAT-1] ? dq_i : data_o;
    end
  assign busy_o = iss_i | (|sr_q);
endmodule

// File: rtl/sdram_read.sv
// sdram_read: read sequencer ACT/tRCD/READ/BST/PRE/tRP with CAS-aligned data return and done pulse.
// Build option SDRAM_RD_AUTO_PRE_EN: READ carries A10=1 and the explicit PRECHARGE is skipped.
module sdram_read
  import sdram_pkg::*;
#(
  parameter int unsigned TRCD_CYC = 2,
  parameter int unsigned TRP_CYC  = 2,
  parameter int unsigned CAS_LAT  = 3
) (
  input  logic        rd_clk,
  input  logic        rd_rst,
  input  logic        rd_en,
  input  logic        init_end,
  input  logic [23:0] rd_addr,
  input  logic [9:0]  rd_bst_len,
  input  logic [15:0] rd_sdram_dq,
  output logic        rd_ack,
  output logic [15:0] rd_data,
  output logic        rd_end,
  output logic [3:0]  rd_sdram_cmd,
  output logic [1:0]  rd_sdram_bank,
  output logic [12:0] rd_sdram_addr
);
`ifdef SDRAM_RD_AUTO_PRE_EN
  localparam logic AUTO_PRE = 1'b1;
`else
  localparam logic AUTO_PRE = 1'b0;
`endif
  rd_state_t   state_q, state_d;
  logic [9:0]  cnt_q, cnt_d, len_q, len_d;
  logic [23:0] addr_q, addr_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [1:0]  bank_q, bank_d;
  logic [12:0] a_q, a_d;
  logic        iss_q, iss_d, end_q, end_d, last, pipe_busy;
  assign last = cnt_q == len_q - 10'd1;
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    cmd_d   = CMD_NOP;
    bank_d  = IDLE_BANK;
    a_d     = IDLE_ADDR;
    end_d   = 1'b0;
    iss_d   = (state_q == ST_RD) || (state_q == ST_DATA && !last);
    unique case (state_q)
      ST_IDLE: if (init_end && rd_en) begin
        state_d = ST_ACT;
        addr_d  = rd_addr;
        len_d   = (rd_bst_len == '0) ? 10'd1 : rd_bst_len;
      end
      ST_ACT: begin
        state_d = ST_TRCD;
        cmd_d   = CMD_ACT;
        bank_d  = addr_q[BANK_MSB:BANK_LSB];
        a_d     = addr_q[ROW_MSB:ROW_LSB];
      end
      ST_TRCD: state_d = (cnt_q == cyc_last(TRCD_CYC)) ? ST_RD : ST_TRCD;
      ST_RD: begin
        state_d = ST_DATA;
        cmd_d   = CMD_RD;
        bank_d  = addr_q[BANK_MSB:BANK_LSB];
        a_d     = {2'b00, AUTO_PRE, 1'b0, addr_q[COL_MSB:COL_LSB]};
      end
      ST_DATA: if (last) begin
        cmd_d   = CMD_BST;
        state_d = AUTO_PRE ? ST_TRP : ST_PRE;
      end
      ST_PRE: begin
        state_d = ST_TRP;
        cmd_d   = CMD_PRE;
        bank_d  = addr_q[BANK_MSB:BANK_LSB];
        a_d     = PRE_ALL_ADDR;
      end
      ST_TRP: state_d = (cnt_q == cyc_last(TRP_CYC)) ? ST_END : ST_TRP;
      ST_END: if (!pipe_busy) begin
        state_d = ST_IDLE;
        end_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    cnt_d = (state_d != state_q || state_q == ST_IDLE) ? '0 : cnt_q + 10'd1;
  end
  always_ff @(posedge rd_clk or posedge rd_rst)
    if (rd_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      cmd_q   <= CMD_NOP;
      bank_q  <= IDLE_BANK;
      a_q     <= IDLE_ADDR;
      iss_q   <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      bank_q  <= bank_d;
      a_q     <= a_d;
      iss_q   <= iss_d;
      end_q   <= end_d;
    end
  sdram_rd_vld_pipe #(.CAS_LAT(CAS_LAT)) u_pipe (
    .clk   (rd_clk),
    .rst   (rd_rst),
    .iss_i (iss_q),
    .dq_i  (rd_sdram_dq),
    .ack_o (rd_ack),
    .data_o(rd_data),
    .busy_o(pipe_busy)
  );
  assign rd_sdram_cmd  = cmd_q;
  assign rd_sdram_bank = bank_q;
  assign rd_sdram_addr = a_q;
  assign rd_end        = end_q;
endmodule

// File: tb/tb_sdram_read.sv
// tb_sdram_read: randomized scoreboard bench for sdram_read with a pin-level SDRAM read-data model.
module tb_sdram_read;
  localparam int TRCD = 2, TRP = 2, CL = 3;
`ifdef SDRAM_RD_AUTO_PRE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, BST = 4'b0110, PRE = 4'b0010;
  logic clk = 1'b0, rst = 1'b1, rd_en = 1'b1, init_end = 1'b0;
  logic [23:0] rd_addr = '0;
  logic [9:0]  rd_bst_len = '0;
  logic [15:0] dq = '0;
  logic        rd_ack, rd_end;
  logic [15:0] rd_data;
  logic [3:0]  cmd;
  logic [1:0]  bank;
  logic [12:0] addr;
  int checks = 0, fails = 0, cyc = 0, ends = 0;
  typedef struct {int t_act; logic [1:0] bank; logic [12:0] row; logic [8:0] col; int len;} req_t;
  req_t rq[$];
  req_t cur;
  logic [15:0] exp_words[$], mem_words[$];
  int step = 0, t_rd = 0, t_bst = 0, t_end = -1, ack_cyc = 0, mem_start = 0, mem_left = 0;

  sdram_read #(.TRCD_CYC(TRCD), .TRP_CYC(TRP), .CAS_LAT(CL)) dut (
    .rd_clk(clk), .rd_rst(rst), .rd_en(rd_en), .init_end(init_end),
    .rd_addr(rd_addr), .rd_bst_len(rd_bst_len), .rd_sdram_dq(dq),
    .rd_ack(rd_ack), .rd_data(rd_data), .rd_end(rd_end),
    .rd_sdram_cmd(cmd), .rd_sdram_bank(bank), .rd_sdram_addr(addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h cycle=%0d", nm, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor plus SDRAM data model, both evaluated away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      step = 0;
      mem_left = 0;
      rq.delete();
      exp_words.delete();
      mem_words.delete();
    end else begin
      if (cmd !== NOP) begin
        if (step == 0) begin
          if (cmd === ACT && rq.size() > 0) begin
            int base, last_ack;
            cur = rq.pop_front();
            chk("act_cycle", cyc, cur.t_act);
            chk("act_bank", bank, cur.bank);
            chk("act_row", addr, cur.row);
            t_rd = cyc + TRCD + 1;
            t_bst = t_rd + cur.len;
            ack_cyc = t_rd + CL + 1;
            base = AUTO ? t_bst : t_bst + 1;
            last_ack = t_rd + CL + cur.len;
            t_end = (base + TRP + 1 > last_ack + 1) ? base + TRP + 1 : last_ack + 1;
            step = 1;
          end else chk("unexpected_cmd", cmd, NOP);
        end else if (step == 1) begin
          chk("rd_cmd", cmd, RD);
          chk("rd_cycle", cyc, t_rd);
          chk("rd_bank", bank, cur.bank);
          chk("rd_addr", addr, {2'b00, AUTO, 1'b0, cur.col});
          mem_start = cyc + CL;
          mem_left = cur.len;
          step = 2;
        end else if (step == 2) begin
          chk("bst_cmd", cmd, BST);
          chk("bst_cycle", cyc, t_bst);
          step = AUTO ? 0 : 3;
        end else begin
          chk("pre_cmd", cmd, PRE);
          chk("pre_cycle", cyc, t_bst + 1);
          chk("pre_bank", bank, cur.bank);
          chk("pre_addr", addr, 13'h0400);
          step = 0;
        end
      end
      if (rd_ack === 1'b1) begin
        if (exp_words.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL extra_ack data=0x%0h cycle=%0d expected no ack", rd_data, cyc);
        end else begin
          chk("ack_data", rd_data, exp_words.pop_front());
          chk("ack_cycle", cyc, ack_cyc);
          ack_cyc++;
        end
      end
      if (rd_end === 1'b1) begin
        ends++;
        chk("end_cycle", cyc, t_end);
      end
    end
    if (mem_left > 0 && cyc >= mem_start && mem_words.size() > 0) begin
      dq = mem_words.pop_front();
      mem_left--;
    end else dq = 16'($urandom);
  end

  task automatic push_req(input logic [23:0] a, input logic [9:0] l);
    req_t r;
    int el;
    el = (l == 0) ? 1 : int'(l);
    r.t_act = cyc + 2;
    r.bank = a[23:22];
    r.row = a[21:9];
    r.col = a[8:0];
    r.len = el;
    for (int i = 0; i < el; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      exp_words.push_back(w);
      mem_words.push_back(w);
    end
    rq.push_back(r);
    rd_en = 1'b1;
    rd_addr = a;
    rd_bst_len = l;
  endtask

  task automatic do_read(input logic [23:0] a, input logic [9:0] l, input int hold);
    int e0, n, el;
    el = (l == 0) ? 1 : int'(l);
    e0 = ends;
    push_req(a, l);
    for (int i = 0; i < hold; i++) @(negedge clk);
    rd_en = 1'b0;
    rd_addr = 24'($urandom);
    rd_bst_len = 10'($urandom);
    n = 0;
    while (ends == e0 && n < el + 100) begin
      @(negedge clk);
      n++;
    end
    if (ends == e0) begin
      checks++;
      fails++;
      $display("FAIL end_timeout len=%0d waited=%0d cycles without rd_end", el, n);
    end
    chk("words_left", exp_words.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cmd", cmd, NOP);
    chk("rst_bank", bank, 2'b11);
    chk("rst_addr", addr, 13'h1fff);
    chk("rst_ack", rd_ack, 1'b0);
    chk("rst_data", rd_data, 16'h0);
    chk("rst_end", rd_end, 1'b0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("noinit_cmd", cmd, NOP);
    chk("noinit_bank", bank, 2'b11);
    chk("noinit_addr", addr, 13'h1fff);
    chk("noinit_ack", rd_ack, 1'b0);
    rd_en = 1'b0;
    init_end = 1'b1;
    @(negedge clk);
    do_read(24'h80_0205, 10'd4, 1);
    do_read(24'($urandom), 10'd1, 2);
    do_read(24'($urandom), 10'd0, 1);
    do_read(24'($urandom), 10'd512, 3);
    push_req(24'($urandom), 10'd8);
    @(negedge clk);
    rd_en = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_cmd", cmd, NOP);
    chk("abort_ack", rd_ack, 1'b0);
    @(negedge clk);
    chk("abort_cmd_next", cmd, NOP);
    chk("abort_ack_next", rd_ack, 1'b0);
    chk("abort_bank", bank, 2'b11);
    chk("abort_addr", addr, 13'h1fff);
    chk("abort_data", rd_data, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_read(24'($urandom), 10'd5, 1);
    for (int k = 0; k < 25; k++)
      do_read(24'($urandom), 10'($urandom_range(0, 24)), int'($urandom_range(1, 3)));
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails + 1);
    $fatal(1, "watchdog");
  end
endmodule
